// File: rtl/tff_bank_ctrl.sv
// tff_bank_ctrl
// Sequences an external bank of WIDTH T flip-flops through a counting run.
// A run is requested with start while idle; the length, wrap value and
// direction are captured at that moment. The bank is cleared for one cycle,
// then driven one count per cycle by toggling exactly the bits that differ
// between the present bank value and the desired next value.
// Optional feature macro: TFF_BANK_CTRL_DOWN_EN enables down-counting via dir.
// Without it the dir port is still present but has no effect.
module tff_bank_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] count_len,
   input  logic [WIDTH-1:0] modulo,
   input  logic             dir,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] t_out,
   output logic             tff_clear,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] steps_left
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } stateT;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   stateT            state;
   stateT            nextState;
   logic [WIDTH-1:0] moduloReg;
   logic [WIDTH-1:0] stepsReg;
   logic [WIDTH-1:0] nxtVal;
   logic             runStart;

`ifdef TFF_BANK_CTRL_DOWN_EN
   logic             dirReg;
`else
   logic             unusedDir;
   assign unusedDir = dir;
`endif

   assign runStart = (state == IDLE) && start;

   // State register. Clear wins over everything, including a start in the
   // same cycle, and drops a run in progress without ever reaching DONE.
   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Run parameters are only taken when a start is accepted from IDLE, so a
   // start arriving while busy cannot disturb the run already in progress.
`ifdef TFF_BANK_CTRL_DOWN_EN
   always_ff @(posedge clock) begin
      if (clear) begin
         moduloReg <= '0;
         dirReg    <= 1'b0;
      end else if (runStart) begin
         moduloReg <= modulo;
         dirReg    <= dir;
      end
   end
`else
   always_ff @(posedge clock) begin
      if (clear) begin
         moduloReg <= '0;
      end else if (runStart) begin
         moduloReg <= modulo;
      end
   end
`endif

   // The step counter doubles as the captured run length: it is loaded on
   // accept, sits still through INIT, and counts down once per RUN cycle so
   // it reaches zero exactly as the run enters DONE.
   always_ff @(posedge clock) begin
      if (clear) begin
         stepsReg <= '0;
      end else if (runStart) begin
         stepsReg <= count_len;
      end else if (state == RUN) begin
         stepsReg <= stepsReg - ONE;
      end
   end

   // Next-state decode. A zero-length run still passes through INIT so the
   // bank is cleared, then goes straight to DONE without any RUN cycles.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = INIT;
            end
         end
         INIT: begin
            if (stepsReg != '0) begin
               nextState = RUN;
            end else begin
               nextState = DONE;
            end
         end
         RUN: begin
            if (stepsReg <= ONE) begin
               nextState = DONE;
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Desired next bank value. Counting up wraps to zero once the bank has
   // reached the wrap value; counting down wraps from zero back to the wrap
   // value, and anything above the wrap value is pulled back to it.
`ifdef TFF_BANK_CTRL_DOWN_EN
   always_comb begin
      nxtVal = '0;
      if (dirReg) begin
         if ((q_fb == '0) || (q_fb > moduloReg)) begin
            nxtVal = moduloReg;
         end else begin
            nxtVal = q_fb - ONE;
         end
      end else begin
         if (q_fb >= moduloReg) begin
            nxtVal = '0;
         end else begin
            nxtVal = q_fb + ONE;
         end
      end
   end
`else
   always_comb begin
      nxtVal = '0;
      if (q_fb >= moduloReg) begin
         nxtVal = '0;
      end else begin
         nxtVal = q_fb + ONE;
      end
   end
`endif

   // A T flip-flop toggles when T is high, so driving the XOR of the present
   // and desired values makes the bank land on the desired value at the next
   // edge. Outside RUN, and whenever clear is up, the bank is left alone.
   always_comb begin
      t_out = '0;
      if ((state == RUN) && !clear) begin
         t_out = q_fb ^ nxtVal;
      end
   end

   assign tff_clear  = clear || (state == INIT);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE) && !clear;
   assign steps_left = stepsReg;

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// tb_tff_bank_ctrl
// Drives tff_bank_ctrl against a behavioural T flip-flop bank and checks each
// run against a reference trace computed from modular arithmetic.
// Honours TFF_BANK_CTRL_DOWN_EN the same way the design does.
module tb_tff_bank_ctrl;

   localparam int WIDTH = 4;
`ifdef TFF_BANK_CTRL_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   typedef struct {
      int q;
      int steps;
      int isDone;
   } expT;

   logic             clock = 1'b0;
   logic             clear;
   logic             start;
   logic [WIDTH-1:0] count_len;
   logic [WIDTH-1:0] modulo;
   logic             dir;
   logic [WIDTH-1:0] q_fb = '0;
   logic [WIDTH-1:0] t_out;
   logic             tff_clear;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] steps_left;

   expT expQ[$];
   int  testsRun = 0;
   int  testsFailed = 0;

   tff_bank_ctrl #(.WIDTH(WIDTH)) dut (
      .clock      (clock),
      .clear      (clear),
      .start      (start),
      .count_len  (count_len),
      .modulo     (modulo),
      .dir        (dir),
      .q_fb       (q_fb),
      .t_out      (t_out),
      .tff_clear  (tff_clear),
      .busy       (busy),
      .done       (done),
      .steps_left (steps_left)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Stand-in for the external bank of T flip-flops.
   always @(posedge clock) begin
      if (tff_clear) begin
         q_fb <= '0;
      end else begin
         q_fb <= q_fb ^ t_out;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Bank value k steps into a run: the bank walks a cycle of length
   // modulo+1 starting from zero, forwards when up, backwards when down.
   function automatic int refValue(input int k, input int m, input bit d);
      int period;
      period = m + 1;
      if (d && DOWN_EN) begin
         return (period - (k % period)) % period;
      end
      return k % period;
   endfunction

   // One expected entry per RUN cycle plus one for the DONE cycle.
   task automatic pushRun(input int len, input int m, input bit d);
      expT e;
      for (int k = 0; k <= len; k++) begin
         e.q      = refValue(k, m, d);
         e.steps  = len - k;
         e.isDone = (k == len) ? 1 : 0;
         expQ.push_back(e);
      end
   endtask

   // Monitor: every cycle the controller is visibly running (busy, not
   // clearing the bank) consumes one scoreboard entry; otherwise no done and
   // no toggling may be seen.
   always @(negedge clock) begin
      expT e;
      if (!clear && busy && !tff_clear) begin
         if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_activity: got busy=%0d done=%0d, expected idle", busy, done);
         end else begin
            e = expQ.pop_front();
            checkOutput("q_fb", int'(q_fb), e.q);
            checkOutput("steps_left", int'(steps_left), e.steps);
            checkOutput("done", int'(done), e.isDone);
         end
      end else begin
         checkOutput("done_outside_run", int'(done), 0);
         checkOutput("t_out_outside_run", int'(t_out), 0);
      end
   end

   task automatic waitIdle();
      int guard;
      guard = 0;
      while (busy && guard < 100) begin
         @(negedge clock);
         guard++;
      end
      if (busy) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL wait_idle_timeout: got busy=%0d, expected 0", busy);
      end
   endtask

   task automatic waitDrain();
      int guard;
      guard = 0;
      while (expQ.size() != 0 && guard < 60) begin
         @(negedge clock);
         guard++;
      end
      if (expQ.size() != 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL run_timeout: got %0d pending, expected 0", expQ.size());
         expQ.delete();
      end
      @(negedge clock);
      checkOutput("busy_after_run", int'(busy), 0);
   endtask

   // One complete run; optionally pokes start with junk while busy to make
   // sure the captured parameters are not disturbed.
   task automatic applyStimulus(input int len, input int m, input bit d, input bit poke);
      waitIdle();
      start     = 1'b1;
      count_len = WIDTH'(len);
      modulo    = WIDTH'(m);
      dir       = d;
      pushRun(len, m, d);
      @(negedge clock);
      start     = 1'b0;
      count_len = WIDTH'($urandom);
      modulo    = WIDTH'($urandom);
      dir       = 1'(~d);
      if (poke) begin
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      waitDrain();
   endtask

   // Clear in the middle of a run with start held high: the run is dropped,
   // nothing is captured while clear is up, and a new run follows.
   task automatic abortRun();
      waitIdle();
      start     = 1'b1;
      count_len = 4'd10;
      modulo    = 4'd15;
      dir       = 1'b0;
      pushRun(10, 15, 1'b0);
      repeat (4) @(negedge clock);
      clear     = 1'b1;
      count_len = 4'd3;
      modulo    = 4'd2;
      expQ.delete();
      repeat (2) @(negedge clock);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_done", int'(done), 0);
      checkOutput("abort_steps_left", int'(steps_left), 0);
      checkOutput("abort_tff_clear", int'(tff_clear), 1);
      checkOutput("abort_t_out", int'(t_out), 0);
      checkOutput("abort_bank", int'(q_fb), 0);
      clear = 1'b0;
      pushRun(3, 2, 1'b0);
      @(negedge clock);
      start = 1'b0;
      waitDrain();
   endtask

   // Watchdog so a stuck design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset checks, directed runs, abort, then random runs.
   initial begin
      clear     = 1'b1;
      start     = 1'b0;
      count_len = '0;
      modulo    = '0;
      dir       = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_t_out", int'(t_out), 0);
      checkOutput("reset_tff_clear", int'(tff_clear), 1);
      checkOutput("reset_steps_left", int'(steps_left), 0);
      clear = 1'b0;
      @(negedge clock);
      checkOutput("idle_tff_clear", int'(tff_clear), 0);

      applyStimulus(5, 9, 1'b0, 1'b0);
      applyStimulus(12, 3, 1'b0, 1'b1);
      applyStimulus(4, 6, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 1'b1);
      applyStimulus(0, 5, 1'b1, 1'b0);
      applyStimulus(15, 0, 1'b1, 1'b0);
      applyStimulus(15, 15, 1'b1, 1'b1);
      abortRun();

      for (int i = 0; i < 30; i++) begin
         applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/tff_bank_ctrl.md
TFF_BANK_CTRL -- requirements
Module: tff_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the number of external T flip-flops sequenced by the block.
REQ-002 Port clock, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port clear, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port start, input, 1, SHALL request one counting run; sampled only in IDLE.
REQ-005 Port count_len, input, WIDTH, SHALL give the number of steps per run; captured on accepted start.
REQ-006 Port modulo, input, WIDTH, SHALL give the wrap value (terminal count); captured on accepted start.
REQ-007 Port dir, input, 1, SHALL select count direction: 0 up, 1 down; captured on accepted start.
REQ-008 Port q_fb, input, WIDTH, SHALL carry the Q outputs of the external T flip-flop bank.
REQ-009 Port t_out, output, WIDTH, SHALL drive the T inputs of the external bank.
REQ-010 Port tff_clear, output, 1, SHALL drive the clear input of the external bank.
REQ-011 Port busy, output, 1, SHALL be high in any state other than IDLE.
REQ-012 Port done, output, 1, SHALL pulse high for exactly one cycle at run completion.
REQ-013 Port steps_left, output, WIDTH, SHALL report the remaining step count.

Function
REQ-014 FSM states SHALL be IDLE, INIT, RUN, DONE, registered, encoded in 2 bits.
REQ-015 IDLE: start=1 SHALL capture count_len, modulo, dir into internal registers and move to INIT next cycle.
REQ-016 INIT: tff_clear SHALL be 1 for exactly one cycle; t_out=0; next state RUN if captured count_len!=0, else DONE.
REQ-017 RUN: t_out SHALL be combinational: t_out = q_fb XOR nxt, so the bank loads nxt on the next edge.
REQ-018 Up: nxt = 0 when q_fb >= modulo_r, else q_fb+1.
REQ-019 Down: nxt = modulo_r when q_fb==0 or q_fb > modulo_r, else q_fb-1.
REQ-020 RUN: steps_left SHALL decrement by 1 each cycle; on the cycle it is 1, next state SHALL be DONE.
REQ-021 DONE: done=1, t_out=0, next state IDLE; a start in DONE SHALL be ignored.
REQ-022 t_out SHALL be all-zero in IDLE, INIT and DONE; tff_clear SHALL be 0 outside INIT and reset.
REQ-023 start while busy=1 SHALL be ignored with no effect on captured values.
REQ-024 Arithmetic SHALL be WIDTH-bit unsigned; modulo=0 SHALL hold the bank at 0 for all steps.
REQ-025 Latency: first bank change SHALL be at the 3rd edge after the start-accept edge; done SHALL assert count_len+2 cycles after the start-accept edge.

Reset
REQ-026 clear=1 SHALL force state IDLE, busy=0, done=0, steps_left=0, t_out=0, internal captured registers to 0.
REQ-027 tff_clear SHALL be 1 combinationally whenever clear=1, so the bank is also cleared.
REQ-028 clear asserted mid-RUN SHALL abort the run without a done pulse; clear SHALL override start in the same cycle.

Configuration
REQ-029 Macro TFF_BANK_CTRL_DOWN_EN SHALL gate down-counting.
REQ-030 Defined: dir behaves per REQ-007/REQ-019.
REQ-031 Undefined: dir port SHALL remain present but be ignored; direction is always up; down-count logic SHALL not be built.

Verification
REQ-032 clear=1 for 3 cycles -> busy=0, done=0, t_out=0, tff_clear=1, steps_left=0.
REQ-033 WIDTH=4, start with count_len=5, modulo=9, dir=0 -> q_fb sequence 0,1,2,3,4,5; done pulse one cycle; busy low after.
REQ-034 count_len=12, modulo=3, dir=0 -> q_fb 0,1,2,3,0,1,2,3,0,1,2,3,0; wrap at 3 each time.
REQ-035 TFF_BANK_CTRL_DOWN_EN defined, count_len=4, modulo=6, dir=1 -> q_fb 0,6,5,4,3; undefined -> 0,1,2,3,4.
REQ-036 count_len=0 -> INIT clears bank, done pulses 2 cycles after accept, no t_out activity.
REQ-037 clear raised after 2 RUN steps with start held high -> IDLE next cycle, no done, bank cleared, new run accepted after clear drops.
